// File: rtl/mem_bus_arbiter.sv
// Two-requester (IF / EX) arbiter for the shared MAR/memory/MDR path.
// It runs one bus transaction at a time, waits on MFC with a timeout, and arbitrates ties round-robin.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ex_req,
  input  logic ex_wr,
  input  logic MFC,
  output logic if_gnt,
  output logic ex_gnt,
  output logic addr_sel,
  output logic MAR_EN,
  output logic MDR_EN_write,
  output logic mem_EN,
  output logic mem_RW,
  output logic MDR_EN_read,
  output logic MDR_out,
  output logic if_done,
  output logic ex_done,
  output logic bus_err
);

  typedef enum logic [2:0] {IDLE, GRANT, MEM, CAPTURE, DONE, ERR} state_t;

  typedef struct packed {
    logic if_gnt;
    logic ex_gnt;
    logic addr_sel;
    logic mar_en;
    logic mdr_en_write;
    logic mem_en;
    logic mem_rw;
    logic mdr_en_read;
    logic mdr_out;
    logic if_done;
    logic ex_done;
    logic bus_err;
  } out_t;

  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;          // 1 = EX owns the bus
  logic          wr_reg, wr_next;
  logic          last_owner_reg, last_owner_next;
  logic [CW-1:0] timer_reg, timer_next;
  logic          pick_ex;
  out_t          out_reg;

  // Moore decode; evaluated on next-state values so the outputs leave a register.
  function automatic out_t decode(input state_t st, input logic own, input logic wr);
    out_t o;
    o = '0;
    o.if_gnt = (st != IDLE) && !own;
    o.ex_gnt = (st != IDLE) && own;
    case (st)
      GRANT: begin
        o.mar_en       = 1'b1;
        o.addr_sel     = own;
        o.mdr_en_write = wr;
      end
      MEM: begin
        o.mem_en  = 1'b1;
        o.mem_rw  = !wr;
        o.mdr_out = wr;
      end
      CAPTURE: begin
        o.mem_en      = 1'b1;
        o.mem_rw      = 1'b1;
        o.mdr_en_read = 1'b1;
      end
      DONE: begin
        o.if_done = !own;
        o.ex_done = own;
        o.mdr_out = !wr;
        o.mem_rw  = !wr;
      end
      ERR: begin
        o.if_done = !own;
        o.ex_done = own;
        o.bus_err = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // On a tie, the bus goes to whoever did not own it last.
  assign pick_ex = (if_req && ex_req) ? !last_owner_reg : ex_req;

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    wr_next         = wr_reg;
    last_owner_next = last_owner_reg;
    timer_next      = timer_reg;
    case (state_reg)
      IDLE: begin
        if (if_req || ex_req) begin
          owner_next = pick_ex;
          wr_next    = pick_ex & ex_wr;
          state_next = GRANT;
        end
      end
      GRANT: begin
        timer_next = '0;
        state_next = MEM;
      end
      MEM: begin
        if (MFC) begin
          state_next = wr_reg ? DONE : CAPTURE;
        end else if (timer_reg == TIMER_LAST) begin
          state_next = ERR;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      CAPTURE: state_next = DONE;
      DONE, ERR: begin
        last_owner_next = owner_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      wr_reg         <= 1'b0;
      last_owner_reg <= 1'b1;
      timer_reg      <= '0;
      out_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      wr_reg         <= wr_next;
      last_owner_reg <= last_owner_next;
      timer_reg      <= timer_next;
      out_reg        <= decode(state_next, owner_next, wr_next);
    end
  end

  assign if_gnt       = out_reg.if_gnt;
  assign ex_gnt       = out_reg.ex_gnt;
  assign addr_sel     = out_reg.addr_sel;
  assign MAR_EN       = out_reg.mar_en;
  assign MDR_EN_write = out_reg.mdr_en_write;
  assign mem_EN       = out_reg.mem_en;
  assign mem_RW       = out_reg.mem_rw;
  assign MDR_EN_read  = out_reg.mdr_en_read;
  assign MDR_out      = out_reg.mdr_out;
  assign if_done      = out_reg.if_done;
  assign ex_done      = out_reg.ex_done;
  assign bus_err      = out_reg.bus_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table-driven transactions, a reset-mid-transaction sequence,
// and randomized traffic checked cycle by cycle against a per-transaction expected trace.
module tb_mem_bus_arbiter;

  localparam int T = 16;

  logic clk, rst, if_req, ex_req, ex_wr, MFC;
  logic if_gnt, ex_gnt, addr_sel, MAR_EN, MDR_EN_write, mem_EN, mem_RW;
  logic MDR_EN_read, MDR_out, if_done, ex_done, bus_err;

  int checks = 0;
  int failures = 0;
  bit last_own;   // 1 = EX was the last owner

  mem_bus_arbiter #(.TIMEOUT(T), .CW(5)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .ex_req(ex_req), .ex_wr(ex_wr), .MFC(MFC),
    .if_gnt(if_gnt), .ex_gnt(ex_gnt), .addr_sel(addr_sel), .MAR_EN(MAR_EN),
    .MDR_EN_write(MDR_EN_write), .mem_EN(mem_EN), .mem_RW(mem_RW),
    .MDR_EN_read(MDR_EN_read), .MDR_out(MDR_out), .if_done(if_done),
    .ex_done(ex_done), .bus_err(bus_err)
  );

  wire [11:0] outs = {if_gnt, ex_gnt, addr_sel, MAR_EN, MDR_EN_write, mem_EN,
                      mem_RW, MDR_EN_read, MDR_out, if_done, ex_done, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Per-phase output word: 0 grant, 1 mem, 2 capture, 3 done, 4 err.
  function automatic logic [11:0] exp_vec(input int ph, input bit own, input bit wr);
    logic [11:0] v;
    v = own ? 12'h400 : 12'h800;
    case (ph)
      0: v = v | (12'(own) << 9) | 12'h100 | (12'(wr) << 7);
      1: v = v | 12'h040 | (12'(!wr) << 5) | (12'(wr) << 3);
      2: v = v | 12'h040 | 12'h020 | 12'h010;
      3: v = v | (own ? 12'h002 : 12'h004) | (wr ? 12'h000 : 12'h028);
      default: v = v | (own ? 12'h002 : 12'h004) | 12'h001;
    endcase
    return v;
  endfunction

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp_own/exp_lat < 0 means "derive from the arbitration rules".
  task automatic run_txn(input string name, input bit ireq, input bit ereq, input bit ewr,
                         input int delay, input int exp_own, input int exp_lat, input bit drop);
    logic [11:0] q[$];
    int ph[$];
    bit own, wr;
    int lat, done_at, m, nmem;
    own = (exp_own >= 0) ? (exp_own != 0) : ((ireq && ereq) ? !last_own : ereq);
    wr = own & ewr;
    nmem = (delay < T) ? delay + 1 : T;
    if (exp_lat >= 0) lat = exp_lat;
    else if (delay >= T) lat = T + 2;
    else lat = wr ? delay + 3 : delay + 4;
    q.push_back(exp_vec(0, own, wr)); ph.push_back(0);
    for (int i = 0; i < nmem; i++) begin q.push_back(exp_vec(1, own, wr)); ph.push_back(1); end
    if (delay >= T) begin
      q.push_back(exp_vec(4, own, wr)); ph.push_back(4);
    end else begin
      if (!wr) begin q.push_back(exp_vec(2, own, wr)); ph.push_back(2); end
      q.push_back(exp_vec(3, own, wr)); ph.push_back(3);
    end
    check({"idle_", name}, outs, 12'h000);
    if_req = ireq; ex_req = ereq; ex_wr = ewr; MFC = 1'($urandom_range(0, 1));
    done_at = -1;
    m = 0;
    for (int k = 0; k < q.size(); k++) begin
      step();
      check($sformatf("%s_c%0d", name, k + 1), outs, q[k]);
      if (done_at < 0 && (if_done || ex_done)) done_at = k + 1;
      if (ph[k] == 1) begin
        MFC = (m == delay);
        m++;
      end else begin
        MFC = 1'($urandom_range(0, 1));
      end
      if (k == q.size() - 1 && drop) begin if_req = 1'b0; ex_req = 1'b0; end
    end
    check({"lat_", name}, 12'(done_at), 12'(lat));
    $display("txn %s own=%s wr=%0d delay=%0d done_at=%0d", name, own ? "EX" : "IF", wr, delay, done_at);
    step();
    last_own = own;
  endtask

  typedef struct {
    string name;
    bit    ireq, ereq, ewr;
    int    delay, exp_own, exp_lat;
    bit    drop;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{"if_read",       1'b1, 1'b0, 1'b0, 0,  0, 4,  1'b1};
    tbl[1] = '{"ex_write_d3",   1'b0, 1'b1, 1'b1, 3,  1, 6,  1'b1};
    tbl[2] = '{"tie1_if",       1'b1, 1'b1, 1'b0, 0,  0, 4,  1'b0};
    tbl[3] = '{"tie2_ex_wr",    1'b1, 1'b1, 1'b1, 1,  1, 4,  1'b0};
    tbl[4] = '{"tie3_if",       1'b1, 1'b1, 1'b0, 2,  0, 6,  1'b1};
    tbl[5] = '{"ex_timeout",    1'b0, 1'b1, 1'b0, 99, 1, 18, 1'b1};
    tbl[6] = '{"if_after_err",  1'b1, 1'b0, 1'b0, 0,  0, 4,  1'b1};
    tbl[7] = '{"ex_read_d2",    1'b0, 1'b1, 1'b0, 2,  1, 6,  1'b1};

    rst = 1'b1; if_req = 1'b0; ex_req = 1'b0; ex_wr = 1'b0; MFC = 1'b0;
    step(); step();
    check("reset_outs", outs, 12'h000);
    rst = 1'b0;
    last_own = 1'b1;
    step();

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].name, tbl[i].ireq, tbl[i].ereq, tbl[i].ewr, tbl[i].delay,
              tbl[i].exp_own, tbl[i].exp_lat, tbl[i].drop);

    // Reset in the middle of an IF read: no done, back to IDLE, IF wins the next tie.
    check("idle_pre_rst", outs, 12'h000);
    if_req = 1'b1; ex_req = 1'b0; MFC = 1'b0;
    step(); check("rst_grant", outs, exp_vec(0, 1'b0, 1'b0));
    if_req = 1'b0;
    step(); check("rst_mem1", outs, exp_vec(1, 1'b0, 1'b0));
    step(); check("rst_mem2", outs, exp_vec(1, 1'b0, 1'b0));
    rst = 1'b1;
    step(); check("rst_applied", outs, 12'h000);
    rst = 1'b0; MFC = 1'b1;
    step(); check("rst_no_done", outs, 12'h000);
    last_own = 1'b1;
    run_txn("post_rst_tie", 1'b1, 1'b1, 1'b1, 0, 0, 4, 1'b1);

    for (int n = 0; n < 40; n++) begin
      int r, d;
      r = $urandom_range(1, 3);
      d = ($urandom_range(0, 7) == 0) ? T + $urandom_range(0, 3) : $urandom_range(0, 4);
      run_txn($sformatf("rnd%0d", n), r[0], r[1], 1'($urandom_range(0, 1)), d, -1, -1,
              1'($urandom_range(0, 1)));
    end
    if_req = 1'b0; ex_req = 1'b0;
    check("final_idle", outs, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences the shared MAR/memory/MDR path and grants it to two requesters: the instruction-fetch unit (IF) and the execute-stage load/store unit (EX).
- Drives the bus strobes for one transaction at a time and waits on the memory MFC handshake, with a timeout.
- Returns a per-requester done pulse; round-robin on simultaneous requests.

Parameters:
TIMEOUT, 16, max MEM-state cycles waiting for MFC before abort (>=2)
CW, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  IF requests a read; held until if_done
ex_req  in  1  EX requests a read or write; held until ex_done
ex_wr  in  1  EX direction, 1=write 0=read; sampled with the grant
MFC  in  1  memory function complete
if_gnt  out  1  bus owned by IF
ex_gnt  out  1  bus owned by EX
addr_sel  out  1  MAR source, 0=PC, 1=EX address register
MAR_EN  out  1  load MAR
MDR_EN_write  out  1  load MDR from EX store data
mem_EN  out  1  memory enable
mem_RW  out  1  1=read, 0=write
MDR_EN_read  out  1  load MDR from memory
MDR_out  out  1  MDR drives internal bus / memory data
if_done  out  1  one-cycle completion pulse to IF
ex_done  out  1  one-cycle completion pulse to EX
bus_err  out  1  one-cycle pulse with done on timeout

Behaviour:
- Moore outputs, decoded from state, owner, and latched wr flag. No input-to-output combinational path.
- States: IDLE, GRANT, MEM, CAPTURE, DONE, ERR.
- Reset (rst=1 at an edge, any state, including mid-transaction):
  - State goes to IDLE; all outputs go to 0.
  - Timer clears; last_owner is set to EX so IF wins the first tie.
- IDLE: all outputs 0.
  - Neither request: stay.
  - One request: latch that owner.
  - Both: latch the requester that is not last_owner.
  - Latch wr = ex_wr if owner is EX, else 0. Go to GRANT.
- GRANT (1 cycle):
  - Owner's gnt=1, MAR_EN=1, addr_sel = (owner==EX).
  - MDR_EN_write=wr.
  - Timer cleared. Go to MEM.
- MEM:
  - gnt=1, mem_EN=1, mem_RW=!wr, MDR_out=wr.
  - MFC=1: read → CAPTURE; write → DONE.
  - MFC=0: timer+1. Timer==TIMEOUT-1 with MFC=0 → ERR.
- CAPTURE (1 cycle): gnt=1, mem_EN=1, mem_RW=1, MDR_EN_read=1. Go to DONE.
- DONE (1 cycle):
  - gnt=1; owner's done=1.
  - Read: MDR_out=1, mem_RW=1, so the requester latches data this cycle.
  - last_owner := owner. Go to IDLE.
- ERR (1 cycle):
  - gnt=1, owner's done=1, bus_err=1; no memory strobes.
  - last_owner := owner. Go to IDLE.
- Latency:
  - Read with MFC high on the first MEM cycle: done asserted 4 cycles after the edge that samples req (GRANT, MEM, CAPTURE, DONE).
  - Write: 3 cycles.
  - Each MFC wait cycle adds 1.
- Timeout: ERR is entered after exactly TIMEOUT MEM cycles without MFC.
- Requester handshake:
  - Requester drops req in the cycle after done.
  - A req still high in IDLE starts a new transaction (back-to-back allowed; round-robin then favours the other requester if it is pending).
- Requests are ignored outside IDLE. A req deasserted mid-transaction does not abort it.
- MFC is ignored outside MEM.
- Never more than one gnt high. done/bus_err are never high outside DONE/ERR.

Test Plan:
- Reset then IF read: if_req=1, MFC=1 on first MEM cycle → GRANT(MAR_EN=1, addr_sel=0), MEM(mem_EN=1, mem_RW=1), CAPTURE(MDR_EN_read=1), DONE(if_done=1, MDR_out=1). if_done 4 cycles after req sampled.
- EX write with MFC delayed 3 cycles: ex_req=1, ex_wr=1 → GRANT with MDR_EN_write=1, addr_sel=1; MEM for 4 cycles with mem_RW=0, MDR_out=1; ex_done at cycle 6; CAPTURE never entered.
- Simultaneous if_req=ex_req=1 held for three transactions after reset → grant order IF, EX, IF. Never both gnt high.
- Timeout with TIMEOUT=16 and MFC held 0 → exactly 16 MEM cycles, then ERR with ex_done=1 and bus_err=1 for one cycle. Next transaction proceeds normally.
- rst=1 during MEM of an IF read → next cycle IDLE with all outputs 0 and no if_done. After reset, simultaneous requests grant IF first.
